rename_wide: RTL and testbench
==============================

Name: rename_wide

Overview:
- W-wide in-order rename/dispatch stage between the decode FIFO and the issue queue, LSQ and ROB.
- Each cycle it renames the longest in-order prefix of up to W decoded instructions that fits the available ROB, issue-queue, LSQ and free-register resources.
- Handles intra-group source-to-dest dependencies with a bypass.
- Drives F-RAT and free-list updates combinationally, and registers the renamed group for the next stage.

Parameters:
W, 2, rename width (slots per cycle, 1..4)
NUM_ARCH, 32, architectural registers
NUM_PHYS, 64, physical registers
LA, 5, log2(NUM_ARCH)
LP, 6, log2(NUM_PHYS)
PW, 128, opaque per-slot payload width (instr, addr, ALU ctrl, imm, shamt, alt PC)
CW, 3, width of free-count inputs (>= log2(W)+1)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
Flush  in  1  squash: no dispatch this cycle; clear outputs
In_valid  in  W  slot i holds a decoded instr; contiguous from slot 0
In_src_a, In_src_b, In_dest  in  W*LA each  architectural regs per slot
In_reg_write, In_mem_read, In_mem_write  in  W each  per-slot decode flags
In_payload  in  W*PW  carried through untouched
Map_flat  in  NUM_ARCH*LP  current F-RAT contents
Busy_phys  in  NUM_PHYS  1 = phys reg not yet written
Free_regs  in  W*LP  next W free-list heads, in order
Free_count, Rob_free, Iq_free, Lsq_free  in  CW each  available entries (saturated at W)
Pop_count  out  CW  comb; FIFO pops this many slots at the edge
Grab_count  out  CW  comb; free-list pops this many
Frat_update  out  W  comb; write enable per slot
Frat_arch  out  W*LA  comb
Frat_phys  out  W*LP  comb
Out_valid  out  W  reg
Out_src_a_phys, Out_src_b_phys  out  W*LP  reg
Out_src_a_rdy, Out_src_b_rdy  out  W  reg
Out_has_dest  out  W  reg
Out_dest_phys  out  W*LP  reg
Out_to_lsq  out  W  reg
Out_payload  out  W*PW  reg
Blocked  out  1  reg
Block_reason  out  3  reg: 0 none, 1 empty, 2 ROB, 3 IQ, 4 LSQ, 5 regs

Behaviour:
- need_dest(i) = In_reg_write[i] && In_dest[i] != 0.
- Slot i dispatches iff all of:
  - every slot j < i dispatches;
  - In_valid[i];
  - i+1 <= Rob_free and i+1 <= Iq_free;
  - count of mem ops (read|write) in slots 0..i <= Lsq_free;
  - count of need_dest in slots 0..i <= Free_count.
- Pop_count = number of dispatched slots.
- Dest assignment: slot i gets Free_regs[k], where k = need_dest count in dispatched slots < i. Grab_count = total need_dest dispatched.
- Frat_update[i] = dispatched && need_dest. If two slots write the same arch reg, both assert; the F-RAT applies them in slot order, so the higher slot wins.
- Source rename for src s of slot i:
  - s == 0: phys 0, rdy 1.
  - Else, if a dispatched slot j < i has need_dest with In_dest[j] == s: the nearest such j's new phys reg, rdy 0.
  - Else Map_flat[s], with rdy = !Busy_phys[that phys].
- Out_to_lsq = mem_read | mem_write. Stores carry no dest.
- Registered outputs update at the CLK edge after the decision: 1-cycle latency.
  - Non-dispatched slots get Out_valid 0; their other Out_* fields are don't-care.
- Blocked = (Pop_count == 0). Block_reason names the first unmet condition for the lowest non-dispatched slot: empty > ROB > IQ > LSQ > regs.
  - Reason 0 when all W slots dispatch.
  - When In_valid[0] = 0, Blocked 1 with reason 1.
- Flush (RESET low): Pop_count, Grab_count, Frat_update forced 0 that cycle; next edge sets Out_valid 0, Blocked 1, Block_reason 0.
- RESET (priority over Flush): next edge sets all registered outputs to 0 except Blocked = 1. Comb outputs are forced 0 while RESET is high.
- Resource inputs above W saturate; values never wrap.

Decomposition:
- rename_pkg holds:
  - default constants for W, NUM_ARCH, NUM_PHYS;
  - Block_reason encodings;
  - a clog2 helper.
- One sub-module, rename_slot_alloc: purely combinational prefix allocator. Inputs are flags and counts; outputs are the dispatch mask and per-slot free-reg index.
- The top module holds source lookup, bypass and output registers.

Test Plan:
- Reset/idle: RESET 1 for 2 cycles, then In_valid=00 → Blocked 1, reason 1, Pop_count 0, Out_valid 00.
- Dual ALU, dependent: slot0 add r3←r1,r2; slot1 add r4←r3,r5; Free_regs={40,41}; Map r1=10, r5=12, Busy all 0 → Pop 2, Grab 2, Frat (3→40),(4→41); next cycle slot1 src_a phys 40 rdy 0, src_b phys 12 rdy 1.
- Partial on regs: both slots write regs, Free_count=1 → Pop 1, Grab 1, Blocked 0, reason 5, Out_valid 01.
- LSQ limit: slot0 lw, slot1 sw, Lsq_free=1 → Pop 1, reason 4. With Lsq_free=0 → Pop 0, Blocked 1, reason 4.
- Same dest in group with r0: slot0 writes r7, slot1 writes r7, slot1 src_a=r0 → Frat_update 11 with phys {40,41}; src_a phys 0 rdy 1. Dest r0 write → Out_has_dest 0, Grab 0.
- Flush mid-flow: valid group, Flush=1 → Pop 0, Frat_update 00; next cycle Out_valid 00. With RESET=1 and Flush=1 together, the reset values win.

Source files
------------

// File: rtl/rename_pkg.sv
// rename_pkg: shared constants, block-reason encodings and a clog2 helper for the rename stage.
package rename_pkg;
  localparam int W_DEF        = 2;
  localparam int NUM_ARCH_DEF = 32;
  localparam int NUM_PHYS_DEF = 64;
  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_EMPTY = 3'd1,
    BR_ROB   = 3'd2,
    BR_IQ    = 3'd3,
    BR_LSQ   = 3'd4,
    BR_REGS  = 3'd5
  } block_reason_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rename_slot_alloc.sv
// rename_slot_alloc: picks the longest in-order dispatchable prefix and each slot's free-list index.
module rename_slot_alloc import rename_pkg::*; #(
  parameter int W  = W_DEF,
  parameter int CW = 3
) (
  input  logic [W-1:0]  valid_i,
  input  logic [W-1:0]  need_dest_i,
  input  logic [W-1:0]  mem_i,
  input  logic [CW-1:0] rob_free_i,
  input  logic [CW-1:0] iq_free_i,
  input  logic [CW-1:0] lsq_free_i,
  input  logic [CW-1:0] free_count_i,
  output logic [W-1:0]  disp_o,
  output logic [CW-1:0] free_idx_o [W],
  output logic [CW-1:0] pop_o,
  output logic [CW-1:0] grab_o,
  output block_reason_e reason_o
);
  always_comb begin
    logic ok;
    logic [CW-1:0] mcnt, dcnt, mn, dn;
    block_reason_e r;
    ok = 1'b1;
    mcnt = '0;
    dcnt = '0;
    pop_o = '0;
    disp_o = '0;
    reason_o = BR_NONE;
    for (int i = 0; i < W; i++) begin
      mn = mcnt + CW'(mem_i[i]);
      dn = dcnt + CW'(need_dest_i[i]);
      r = !valid_i[i]                 ? BR_EMPTY :
          CW'(i + 1) > rob_free_i     ? BR_ROB   :
          CW'(i + 1) > iq_free_i      ? BR_IQ    :
          mn > lsq_free_i             ? BR_LSQ   :
          dn > free_count_i           ? BR_REGS  : BR_NONE;
      free_idx_o[i] = dcnt;
      disp_o[i] = ok && (r == BR_NONE);
      if (ok && r != BR_NONE) reason_o = r;
      ok = disp_o[i];
      if (ok) begin
        mcnt = mn;
        dcnt = dn;
        pop_o = CW'(i + 1);
      end
    end
    grab_o = dcnt;
  end
endmodule

// File: rtl/rename_wide.sv
// rename_wide: W-wide in-order rename/dispatch with intra-group bypass and a registered output group.
module rename_wide import rename_pkg::*; #(
  parameter int W        = W_DEF,
  parameter int NUM_ARCH = NUM_ARCH_DEF,
  parameter int NUM_PHYS = NUM_PHYS_DEF,
  parameter int LA       = clog2(NUM_ARCH),
  parameter int LP       = clog2(NUM_PHYS),
  parameter int PW       = 128,
  parameter int CW       = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   Flush,
  input  logic [W-1:0]           In_valid,
  input  logic [W*LA-1:0]        In_src_a,
  input  logic [W*LA-1:0]        In_src_b,
  input  logic [W*LA-1:0]        In_dest,
  input  logic [W-1:0]           In_reg_write,
  input  logic [W-1:0]           In_mem_read,
  input  logic [W-1:0]           In_mem_write,
  input  logic [W*PW-1:0]        In_payload,
  input  logic [NUM_ARCH*LP-1:0] Map_flat,
  input  logic [NUM_PHYS-1:0]    Busy_phys,
  input  logic [W*LP-1:0]        Free_regs,
  input  logic [CW-1:0]          Free_count,
  input  logic [CW-1:0]          Rob_free,
  input  logic [CW-1:0]          Iq_free,
  input  logic [CW-1:0]          Lsq_free,
  output logic [CW-1:0]          Pop_count,
  output logic [CW-1:0]          Grab_count,
  output logic [W-1:0]           Frat_update,
  output logic [W*LA-1:0]        Frat_arch,
  output logic [W*LP-1:0]        Frat_phys,
  output logic [W-1:0]           Out_valid,
  output logic [W*LP-1:0]        Out_src_a_phys,
  output logic [W*LP-1:0]        Out_src_b_phys,
  output logic [W-1:0]           Out_src_a_rdy,
  output logic [W-1:0]           Out_src_b_rdy,
  output logic [W-1:0]           Out_has_dest,
  output logic [W*LP-1:0]        Out_dest_phys,
  output logic [W-1:0]           Out_to_lsq,
  output logic [W*PW-1:0]        Out_payload,
  output logic                   Blocked,
  output logic [2:0]             Block_reason
);
  logic kill;
  logic [LA-1:0] sa [W], sb [W], dst [W];
  logic [LP-1:0] map [NUM_ARCH], free_a [W], dphys [W];
  logic [W-1:0] nd, mem, disp, fu;
  logic [CW-1:0] free_idx [W], pop, grab;
  block_reason_e reason, reason_q;
  logic [W*LP-1:0] pa_d, pb_d, dp_d, pa_q, pb_q, dp_q;
  logic [W-1:0] ra_d, rb_d, ra_q, rb_q, valid_q, hd_q, lsq_q;
  logic [W*PW-1:0] pay_q;
  logic blocked_q;
  assign kill = RESET | Flush;
  always_comb begin
    nd = '0;
    mem = '0;
    for (int i = 0; i < W; i++) begin
      sa[i] = In_src_a[i*LA +: LA];
      sb[i] = In_src_b[i*LA +: LA];
      dst[i] = In_dest[i*LA +: LA];
      free_a[i] = Free_regs[i*LP +: LP];
      nd[i] = In_reg_write[i] && (dst[i] != '0);
      mem[i] = In_mem_read[i] | In_mem_write[i];
    end
    for (int a = 0; a < NUM_ARCH; a++) map[a] = Map_flat[a*LP +: LP];
  end
  rename_slot_alloc #(.W(W), .CW(CW)) u_alloc (
    .valid_i      (In_valid),
    .need_dest_i  (nd),
    .mem_i        (mem),
    .rob_free_i   (Rob_free),
    .iq_free_i    (Iq_free),
    .lsq_free_i   (Lsq_free),
    .free_count_i (Free_count),
    .disp_o       (disp),
    .free_idx_o   (free_idx),
    .pop_o        (pop),
    .grab_o       (grab),
    .reason_o     (reason)
  );
  assign fu          = disp & nd;
  assign Frat_update = kill ? '0 : fu;
  assign Pop_count   = kill ? '0 : pop;
  assign Grab_count  = kill ? '0 : grab;
  always_comb begin
    logic [LP-1:0] pa, pb;
    logic ra, rb;
    pa_d = '0;
    pb_d = '0;
    dp_d = '0;
    ra_d = '0;
    rb_d = '0;
    Frat_arch = '0;
    Frat_phys = '0;
    for (int i = 0; i < W; i++) begin
      dphys[i] = '0;
      for (int k = 0; k < W; k++) if (free_idx[i] == CW'(k)) dphys[i] = free_a[k];
      pa = map[sa[i]];
      ra = !Busy_phys[pa];
      pb = map[sb[i]];
      rb = !Busy_phys[pb];
      // ascending scan leaves the nearest older in-group writer in place
      for (int j = 0; j < i; j++) begin
        if (fu[j] && dst[j] == sa[i]) begin
          pa = dphys[j];
          ra = 1'b0;
        end
        if (fu[j] && dst[j] == sb[i]) begin
          pb = dphys[j];
          rb = 1'b0;
        end
      end
      if (sa[i] == '0) begin
        pa = '0;
        ra = 1'b1;
      end
      if (sb[i] == '0) begin
        pb = '0;
        rb = 1'b1;
      end
      pa_d[i*LP +: LP] = pa;
      pb_d[i*LP +: LP] = pb;
      ra_d[i] = ra;
      rb_d[i] = rb;
      dp_d[i*LP +: LP] = nd[i] ? dphys[i] : '0;
      Frat_arch[i*LA +: LA] = Frat_update[i] ? dst[i] : '0;
      Frat_phys[i*LP +: LP] = Frat_update[i] ? dphys[i] : '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      pa_q <= '0;
      pb_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      hd_q <= '0;
      dp_q <= '0;
      lsq_q <= '0;
      pay_q <= '0;
      blocked_q <= 1'b1;
      reason_q <= BR_NONE;
    end else begin
      valid_q <= Flush ? '0 : disp;
      pa_q <= pa_d;
      pb_q <= pb_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      hd_q <= nd;
      dp_q <= dp_d;
      lsq_q <= mem;
      pay_q <= In_payload;
      blocked_q <= Flush || !disp[0];
      reason_q <= Flush ? BR_NONE : reason;
    end
  end
  assign Out_valid      = valid_q;
  assign Out_src_a_phys = pa_q;
  assign Out_src_b_phys = pb_q;
  assign Out_src_a_rdy  = ra_q;
  assign Out_src_b_rdy  = rb_q;
  assign Out_has_dest   = hd_q;
  assign Out_dest_phys  = dp_q;
  assign Out_to_lsq     = lsq_q;
  assign Out_payload    = pay_q;
  assign Blocked        = blocked_q;
  assign Block_reason   = reason_q;
endmodule

// File: tb/tb_rename_wide.sv
// tb_rename_wide: directed and randomized checks of rename_wide against a prefix-search reference model.
module tb_rename_wide;
  localparam int W = 2, NA = 32, NP = 64, LA = 5, LP = 6, PW = 128, CW = 3;
  logic CLK = 0, RESET = 1, Flush = 0;
  logic [W-1:0] In_valid, In_reg_write, In_mem_read, In_mem_write;
  logic [W*LA-1:0] In_src_a, In_src_b, In_dest;
  logic [W*PW-1:0] In_payload;
  logic [NA*LP-1:0] Map_flat;
  logic [NP-1:0] Busy_phys;
  logic [W*LP-1:0] Free_regs;
  logic [CW-1:0] Free_count, Rob_free, Iq_free, Lsq_free;
  logic [CW-1:0] Pop_count, Grab_count;
  logic [W-1:0] Frat_update, Out_valid, Out_src_a_rdy, Out_src_b_rdy, Out_has_dest, Out_to_lsq;
  logic [W*LA-1:0] Frat_arch;
  logic [W*LP-1:0] Frat_phys, Out_src_a_phys, Out_src_b_phys, Out_dest_phys;
  logic [W*PW-1:0] Out_payload;
  logic Blocked;
  logic [2:0] Block_reason;
  int n_chk = 0, n_pass = 0;

  rename_wide #(.W(W), .NUM_ARCH(NA), .NUM_PHYS(NP), .LA(LA), .LP(LP), .PW(PW), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .Flush(Flush), .In_valid(In_valid), .In_src_a(In_src_a),
    .In_src_b(In_src_b), .In_dest(In_dest), .In_reg_write(In_reg_write), .In_mem_read(In_mem_read),
    .In_mem_write(In_mem_write), .In_payload(In_payload), .Map_flat(Map_flat), .Busy_phys(Busy_phys),
    .Free_regs(Free_regs), .Free_count(Free_count), .Rob_free(Rob_free), .Iq_free(Iq_free),
    .Lsq_free(Lsq_free), .Pop_count(Pop_count), .Grab_count(Grab_count), .Frat_update(Frat_update),
    .Frat_arch(Frat_arch), .Frat_phys(Frat_phys), .Out_valid(Out_valid), .Out_src_a_phys(Out_src_a_phys),
    .Out_src_b_phys(Out_src_b_phys), .Out_src_a_rdy(Out_src_a_rdy), .Out_src_b_rdy(Out_src_b_rdy),
    .Out_has_dest(Out_has_dest), .Out_dest_phys(Out_dest_phys), .Out_to_lsq(Out_to_lsq),
    .Out_payload(Out_payload), .Blocked(Blocked), .Block_reason(Block_reason)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit nd(input int j);
    return In_reg_write[j] && (In_dest[j*LA +: LA] != '0);
  endfunction
  function automatic bit mm(input int j);
    return In_mem_read[j] | In_mem_write[j];
  endfunction

  // reference model state: current decision (e_*) and the one the registers should now hold (p_*)
  int e_pop, e_grab, e_reason, p_pop, p_reason;
  bit e_rst, e_flush, p_rst, p_flush, have_prev = 0;
  logic [W-1:0] e_val, e_fu, e_hd, e_lsq, e_ra, e_rb, p_val, p_hd, p_lsq, p_ra, p_rb;
  logic [LP-1:0] e_pa [W], e_pb [W], e_dp [W], p_pa [W], p_pb [W], p_dp [W];
  logic [LA-1:0] e_fa [W];
  logic [W*PW-1:0] p_pay;

  task automatic lookup(input logic [LA-1:0] s, input int i, output logic [LP-1:0] p, output logic r);
    if (s == '0) begin
      p = '0;
      r = 1'b1;
    end else begin
      p = Map_flat[s*LP +: LP];
      r = !Busy_phys[p];
      for (int j = 0; j < i; j++)
        if (nd(j) && In_dest[j*LA +: LA] == s) begin
          p = e_dp[j];
          r = 1'b0;
        end
    end
  endtask

  task automatic model();
    int n, k, dc, mc;
    bit ok;
    n = 0;
    for (int c = 1; c <= W; c++) begin
      ok = (c <= int'(Rob_free)) && (c <= int'(Iq_free));
      dc = 0;
      mc = 0;
      for (int j = 0; j < c; j++) begin
        ok &= In_valid[j];
        dc += int'(nd(j));
        mc += int'(mm(j));
      end
      ok &= (mc <= int'(Lsq_free)) && (dc <= int'(Free_count));
      if (ok && n == c - 1) n = c;
    end
    e_reason = 0;
    if (n < W) begin
      dc = 0;
      mc = 0;
      for (int j = 0; j <= n; j++) begin
        dc += int'(nd(j));
        mc += int'(mm(j));
      end
      e_reason = !In_valid[n] ? 1 : (n + 1 > int'(Rob_free)) ? 2 : (n + 1 > int'(Iq_free)) ? 3 :
                 (mc > int'(Lsq_free)) ? 4 : 5;
    end
    e_val = '0; e_fu = '0; e_hd = '0; e_lsq = '0; e_ra = '0; e_rb = '0;
    k = 0;
    for (int i = 0; i < W; i++) begin
      e_dp[i] = '0;
      e_fa[i] = In_dest[i*LA +: LA];
      if (i < n) begin
        e_val[i] = 1'b1;
        e_hd[i] = nd(i);
        e_lsq[i] = mm(i);
        e_fu[i] = nd(i);
        if (nd(i)) begin
          e_dp[i] = Free_regs[k*LP +: LP];
          k++;
        end
      end
    end
    for (int i = 0; i < W; i++) begin
      lookup(In_src_a[i*LA +: LA], i, e_pa[i], e_ra[i]);
      lookup(In_src_b[i*LA +: LA], i, e_pb[i], e_rb[i]);
    end
    e_pop = n;
    e_grab = k;
    e_rst = RESET;
    e_flush = Flush;
  endtask

  always @(negedge CLK) begin
    model();
    chk("pop", Pop_count, (e_rst || e_flush) ? 0 : e_pop);
    chk("grab", Grab_count, (e_rst || e_flush) ? 0 : e_grab);
    chk("frat_update", Frat_update, (e_rst || e_flush) ? '0 : e_fu);
    for (int i = 0; i < W; i++) begin
      if (e_rst) begin
        chk($sformatf("frat_arch%0d_rst", i), Frat_arch[i*LA +: LA], 0);
        chk($sformatf("frat_phys%0d_rst", i), Frat_phys[i*LP +: LP], 0);
      end else if (!e_flush && e_fu[i]) begin
        chk($sformatf("frat_arch%0d", i), Frat_arch[i*LA +: LA], e_fa[i]);
        chk($sformatf("frat_phys%0d", i), Frat_phys[i*LP +: LP], e_dp[i]);
      end
    end
    if (have_prev) begin
      chk("out_valid", Out_valid, (p_rst || p_flush) ? '0 : p_val);
      chk("blocked", Blocked, (p_rst || p_flush) ? 1 : (p_pop == 0));
      chk("block_reason", Block_reason, (p_rst || p_flush) ? 0 : p_reason);
      if (p_rst) begin
        chk("rst_fields", {Out_src_a_phys, Out_src_b_phys, Out_src_a_rdy, Out_src_b_rdy,
                           Out_has_dest, Out_dest_phys, Out_to_lsq}, 0);
        chk("rst_payload", Out_payload, 0);
      end else if (!p_flush) begin
        for (int i = 0; i < W; i++) if (p_val[i]) begin
          chk($sformatf("src_a%0d", i), {Out_src_a_rdy[i], Out_src_a_phys[i*LP +: LP]}, {p_ra[i], p_pa[i]});
          chk($sformatf("src_b%0d", i), {Out_src_b_rdy[i], Out_src_b_phys[i*LP +: LP]}, {p_rb[i], p_pb[i]});
          chk($sformatf("has_dest%0d", i), Out_has_dest[i], p_hd[i]);
          if (p_hd[i]) chk($sformatf("dest%0d", i), Out_dest_phys[i*LP +: LP], p_dp[i]);
          chk($sformatf("to_lsq%0d", i), Out_to_lsq[i], p_lsq[i]);
          chk($sformatf("payload%0d", i), Out_payload[i*PW +: PW], p_pay[i*PW +: PW]);
        end
      end
    end
    p_pop = e_pop; p_reason = e_reason; p_rst = e_rst; p_flush = e_flush;
    p_val = e_val; p_hd = e_hd; p_lsq = e_lsq; p_ra = e_ra; p_rb = e_rb;
    p_pa = e_pa; p_pb = e_pb; p_dp = e_dp; p_pay = In_payload;
    have_prev = 1;
  end

  task automatic clear();
    In_valid = '0; In_reg_write = '0; In_mem_read = '0; In_mem_write = '0;
    In_src_a = '0; In_src_b = '0; In_dest = '0;
  endtask
  task automatic slot(input int i, input int sa, input int sb, input int d, input bit rw, input bit mr, input bit mw);
    In_valid[i] = 1'b1;
    In_src_a[i*LA +: LA] = LA'(sa);
    In_src_b[i*LA +: LA] = LA'(sb);
    In_dest[i*LA +: LA] = LA'(d);
    In_reg_write[i] = rw;
    In_mem_read[i] = mr;
    In_mem_write[i] = mw;
  endtask
  task automatic comb_phase();
    @(negedge CLK);
    #1;
  endtask
  task automatic reg_phase();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    clear();
    In_payload = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0123};
    for (int a = 0; a < NA; a++) Map_flat[a*LP +: LP] = LP'(a);
    Busy_phys = '0;
    Free_regs = {6'd41, 6'd40};
    Free_count = 7; Rob_free = 7; Iq_free = 7; Lsq_free = 7;
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    comb_phase();
    chk("d_idle_pop", Pop_count, 0);
    reg_phase();
    chk("d_idle_blocked", {Blocked, Block_reason, Out_valid}, {1'b1, 3'd1, 2'b00});
    Map_flat[1*LP +: LP] = 6'd10;
    Map_flat[5*LP +: LP] = 6'd12;
    slot(0, 1, 2, 3, 1, 0, 0);
    slot(1, 3, 5, 4, 1, 0, 0);
    comb_phase();
    chk("d_dep_counts", {Pop_count, Grab_count, Frat_update}, {3'd2, 3'd2, 2'b11});
    chk("d_dep_frat", {Frat_arch, Frat_phys}, {5'd4, 5'd3, 6'd41, 6'd40});
    reg_phase();
    chk("d_dep_s1a", {Out_src_a_rdy[1], Out_src_a_phys[LP +: LP]}, {1'b0, 6'd40});
    chk("d_dep_s1b", {Out_src_b_rdy[1], Out_src_b_phys[LP +: LP]}, {1'b1, 6'd12});
    chk("d_dep_s0a", {Out_src_a_rdy[0], Out_src_a_phys[0 +: LP]}, {1'b1, 6'd10});
    Free_count = 1;
    comb_phase();
    chk("d_regs_counts", {Pop_count, Grab_count}, {3'd1, 3'd1});
    reg_phase();
    chk("d_regs_out", {Blocked, Block_reason, Out_valid}, {1'b0, 3'd5, 2'b01});
    Free_count = 7;
    clear();
    slot(0, 1, 0, 8, 1, 1, 0);
    slot(1, 2, 8, 0, 0, 0, 1);
    Lsq_free = 1;
    comb_phase();
    chk("d_lsq1_pop", Pop_count, 1);
    reg_phase();
    chk("d_lsq1_out", {Block_reason, Out_valid, Out_to_lsq[0]}, {3'd4, 2'b01, 1'b1});
    Lsq_free = 0;
    comb_phase();
    chk("d_lsq0_pop", Pop_count, 0);
    reg_phase();
    chk("d_lsq0_out", {Blocked, Block_reason, Out_valid}, {1'b1, 3'd4, 2'b00});
    Lsq_free = 7;
    clear();
    slot(0, 1, 2, 7, 1, 0, 0);
    slot(1, 0, 7, 7, 1, 0, 0);
    comb_phase();
    chk("d_same_frat", {Frat_update, Frat_arch, Frat_phys}, {2'b11, 5'd7, 5'd7, 6'd41, 6'd40});
    reg_phase();
    chk("d_same_s1a", {Out_src_a_rdy[1], Out_src_a_phys[LP +: LP]}, {1'b1, 6'd0});
    chk("d_same_s1b", {Out_src_b_rdy[1], Out_src_b_phys[LP +: LP]}, {1'b0, 6'd40});
    clear();
    slot(0, 1, 2, 0, 1, 0, 0);
    comb_phase();
    chk("d_r0_grab", {Pop_count, Grab_count, Frat_update}, {3'd1, 3'd0, 2'b00});
    reg_phase();
    chk("d_r0_out", {Out_valid, Out_has_dest}, {2'b01, 2'b00});
    clear();
    slot(0, 1, 2, 3, 1, 0, 0);
    slot(1, 3, 5, 4, 1, 0, 0);
    Flush = 1;
    comb_phase();
    chk("d_flush_comb", {Pop_count, Grab_count, Frat_update}, 0);
    reg_phase();
    chk("d_flush_out", {Out_valid, Blocked, Block_reason}, {2'b00, 1'b1, 3'd0});
    RESET = 1;
    comb_phase();
    chk("d_rstfl_comb", {Pop_count, Grab_count, Frat_update, Frat_arch, Frat_phys}, 0);
    reg_phase();
    chk("d_rstfl_out", {Out_valid, Blocked, Block_reason, Out_src_a_phys, Out_dest_phys}, {2'b00, 1'b1, 3'd0, 12'd0, 12'd0});
    RESET = 0;
    Flush = 0;
    repeat (400) begin
      RESET = ($urandom_range(0, 49) == 0);
      Flush = ($urandom_range(0, 15) == 0);
      In_valid = W'((1 << $urandom_range(0, W)) - 1);
      In_reg_write = W'($urandom);
      In_mem_read = W'($urandom);
      In_mem_write = W'($urandom);
      for (int i = 0; i < W; i++) begin
        In_src_a[i*LA +: LA] = LA'($urandom_range(0, 7));
        In_src_b[i*LA +: LA] = LA'($urandom_range(0, 7));
        In_dest[i*LA +: LA] = LA'($urandom_range(0, 7));
        In_payload[i*PW +: PW] = {$urandom, $urandom, $urandom, $urandom};
        Free_regs[i*LP +: LP] = LP'($urandom);
      end
      for (int a = 0; a < NA; a++) Map_flat[a*LP +: LP] = LP'($urandom);
      Busy_phys = {$urandom, $urandom};
      Free_count = CW'($urandom_range(0, 7));
      Rob_free = CW'($urandom_range(0, 7));
      Iq_free = CW'($urandom_range(0, 7));
      Lsq_free = CW'($urandom_range(0, 7));
      reg_phase();
    end
    comb_phase();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
